ex_stage_fwd_mdu: RTL and testbench



---
 rtl/ex_stage_fwd_mdu.sv | 195 +++++++++++++++++++
 tb/tb_ex_stage_fwd_mdu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ex_stage_fwd_mdu.sv
// Execute stage: operand forwarding, ALU, registered result and an optional
// iterative multiply/divide unit (built when EX_MULDIV_EN is defined).
module ex_stage_fwd_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] write_data,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [XLEN-1:0] store_data
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] op_a, fwd_rs2, op_b, alu_res;
  logic [SHW-1:0]  shamt;
  logic            is_mdu;

  always_comb begin
    case (forwardA)
      2'b10:   op_a = ex_mem_alu_result;
      2'b01:   op_a = write_data;
      default: op_a = rs1_data;
    endcase
    case (forwardB)
      2'b10:   fwd_rs2 = ex_mem_alu_result;
      2'b01:   fwd_rs2 = write_data;
      default: fwd_rs2 = rs2_data;
    endcase
  end

  assign op_b   = alu_src ? imm : fwd_rs2;
  assign shamt  = op_b[SHW-1:0];
  assign is_mdu = (alu_op == 2'b10) && (funct7 == 7'b0000001);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      default: begin
        // funct7 only distinguishes SUB in R-type; in I-type it matters only for SRAI
        case (funct3)
          3'b000: alu_res = (alu_op == 2'b10 && funct7[5]) ? op_a - op_b : op_a + op_b;
          3'b001: alu_res = op_a << shamt;
          3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
          3'b100: alu_res = op_a ^ op_b;
          3'b101: alu_res = funct7[5] ? XLEN'($signed(op_a) >>> shamt) : op_a >> shamt;
          3'b110: alu_res = op_a | op_b;
          default: alu_res = op_a & op_b;
        endcase
      end
    endcase
    if (is_mdu) alu_res = '0;
  end

`ifdef EX_MULDIV_EN
  // state  | meaning
  // S_IDLE | waiting; MDU op present latches operands
  // S_BUSY | one shift-add / restoring-divide step per cycle, XLEN steps
  // S_DONE | result captured into output register
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t state, state_nxt;

  logic            mdu_start, mdu_done, neg;
  logic [XLEN-1:0] hi, lo, dvs, sd_lat, mdu_result, a_mag, b_mag, div_r;
  logic [SHW-1:0]  cnt;
  logic [2:0]      f3_lat;
  logic            a_sgn, b_sgn, a_neg, b_neg, div_ge;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod_s;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid && is_mdu) state_nxt = S_BUSY;
      S_BUSY: if (cnt == '0) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mdu_start = 1'b0;
    mdu_done  = 1'b0;
    case (state)
      S_IDLE: begin
        mdu_start = in_valid && is_mdu;
        stall     = mdu_start;
      end
      S_BUSY: stall = 1'b1;
      S_DONE: mdu_done = 1'b1;
      default: ;
    endcase
    if (rst) begin
      stall     = 1'b0;
      mdu_start = 1'b0;
      mdu_done  = 1'b0;
    end
  end

  assign a_sgn = funct3[2] ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
  assign b_sgn = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);
  assign a_neg = a_sgn & op_a[XLEN-1];
  assign b_neg = b_sgn & fwd_rs2[XLEN-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -fwd_rs2 : fwd_rs2;

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
  assign div_sh   = {hi, lo[XLEN-1]};
  assign div_ge   = div_sh >= {1'b0, dvs};
  assign div_diff = div_sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (mdu_start) begin
      hi     <= '0;
      lo     <= funct3[2] ? a_mag : b_mag;
      dvs    <= funct3[2] ? b_mag : a_mag;
      cnt    <= SHW'(XLEN-1);
      f3_lat <= funct3;
      sd_lat <= fwd_rs2;
      // divide by zero keeps an all-ones quotient; remainder sign follows dividend
      neg    <= funct3[2] ? (funct3[1] ? a_neg : (a_neg ^ b_neg) & (|fwd_rs2))
                          : (a_neg ^ b_neg);
    end else if (state == S_BUSY) begin
      cnt <= cnt - 1'b1;
      if (f3_lat[2]) begin
        hi <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        lo <= {lo[XLEN-2:0], div_ge};
      end else begin
        hi <= mul_sum[XLEN:1];
        lo <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  assign prod_s = neg ? -{hi, lo} : {hi, lo};
  assign div_r  = f3_lat[1] ? hi : lo;

  always_comb begin
    if (f3_lat[2])               mdu_result = neg ? -div_r : div_r;
    else if (f3_lat[1:0] == 2'b00) mdu_result = prod_s[XLEN-1:0];
    else                         mdu_result = prod_s[2*XLEN-1:XLEN];
  end
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero       <= 1'b1;
      store_data <= '0;
`ifdef EX_MULDIV_EN
    end else if (mdu_done) begin
      out_valid  <= 1'b1;
      alu_result <= mdu_result;
      zero       <= (mdu_result == '0);
      store_data <= sd_lat;
    end else if (stall) begin
      out_valid  <= 1'b0;
`endif
    end else if (in_valid) begin
      out_valid  <= 1'b1;
      alu_result <= alu_res;
      zero       <= (alu_res == '0);
      store_data <= fwd_rs2;
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_fwd_mdu.sv
// Scoreboard bench for ex_stage_fwd_mdu (XLEN=32); MDU cases run when
// EX_MULDIV_EN is defined, otherwise the disabled-MDU behaviour is checked.
module tb_ex_stage_fwd_mdu;
  logic        clk = 1'b0;
  logic        rst, in_valid, alu_src;
  logic [31:0] rs1_data, rs2_data, imm, ex_mem_alu_result, write_data;
  logic [1:0]  alu_op, forwardA, forwardB;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        stall, out_valid, zero;
  logic [31:0] alu_result, store_data;

  typedef struct {
    logic [31:0] r;
    logic [31:0] sd;
    int          t0;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   late_cnt;

  ex_stage_fwd_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_src(alu_src), .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
    .forwardA(forwardA), .forwardB(forwardB),
    .ex_mem_alu_result(ex_mem_alu_result), .write_data(write_data),
    .stall(stall), .out_valid(out_valid), .alu_result(alu_result),
    .zero(zero), .store_data(store_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_res"},  alu_result, e.r);
        chk({e.tag, "_zero"}, zero, (e.r == 32'd0));
        chk({e.tag, "_sd"},   store_data, e.sd);
        chk({e.tag, "_lat"},  cyc - e.t0, e.lat);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input string tag, input logic [31:0] a, b, im, input logic src,
                       input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [1:0] fa, fb, input logic [31:0] exm, wd,
                       input logic [31:0] exp_r, exp_sd, input int exp_lat, exp_stall);
    exp_t e;
    int   n;
    in_valid = 1'b1; rs1_data = a; rs2_data = b; imm = im; alu_src = src;
    alu_op = aop; funct3 = f3; funct7 = f7; forwardA = fa; forwardB = fb;
    ex_mem_alu_result = exm; write_data = wd;
    e.r = exp_r; e.sd = exp_sd; e.t0 = cyc; e.lat = exp_lat; e.tag = tag;
    sb.push_back(e);
    #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
      ex_mem_alu_result = $urandom;
      write_data        = $urandom;
      #1;
    end
    chk({tag, "_stall_cycles"}, n, exp_stall);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; rs1_data = '0; rs2_data = '0; imm = '0; alu_src = 1'b0;
    alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'b0; forwardA = 2'b00; forwardB = 2'b00;
    ex_mem_alu_result = '0; write_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid",  out_valid, 0);
    chk("rst_alu_result", alu_result, 0);
    chk("rst_zero",       zero, 1);
    chk("rst_store_data", store_data, 0);
    chk("rst_stall",      stall, 0);
    rst = 1'b0;
    @(negedge clk);

    //     tag      rs1          rs2          imm          src op     f3      f7           fa     fb     exm          wd          exp_r        exp_sd      lat stall
    issue("add",   32'd5,       32'd7,       32'd0,       0, 2'b00, 3'b000, 7'b0000000, 2'b10, 2'b00, 32'd100,     32'd0,      32'd107,     32'd7,      1, 0);
    issue("sub",   32'd9,       32'd9,       32'd0,       0, 2'b01, 3'b000, 7'b0000000, 2'b00, 2'b00, 32'd0,       32'd0,      32'd0,       32'd9,      1, 0);
    issue("sra",   32'h80000000,32'd4,       32'd0,       0, 2'b10, 3'b101, 7'b0100000, 2'b00, 2'b00, 32'd0,       32'd0,      32'hF8000000,32'd4,      1, 0);
    issue("slt",   32'hFFFFFFFF,32'd1,       32'd0,       0, 2'b10, 3'b010, 7'b0000000, 2'b00, 2'b00, 32'd0,       32'd0,      32'd1,       32'd1,      1, 0);
    issue("sltu",  32'hFFFFFFFF,32'd1,       32'd0,       0, 2'b10, 3'b011, 7'b0000000, 2'b00, 2'b00, 32'd0,       32'd0,      32'd0,       32'd1,      1, 0);
    issue("xori",  32'hFFFF0000,32'h55,      32'h00000F0F,1, 2'b11, 3'b100, 7'b0000000, 2'b00, 2'b00, 32'd0,       32'd0,      32'hFFFF0F0F,32'h55,     1, 0);
    issue("srli",  32'h80000000,32'd0,       32'd4,       1, 2'b11, 3'b101, 7'b0000000, 2'b00, 2'b00, 32'd0,       32'd0,      32'h08000000,32'd0,      1, 0);
    issue("srai",  32'h80000000,32'd0,       32'h00000404,1, 2'b11, 3'b101, 7'b0100000, 2'b00, 2'b00, 32'd0,       32'd0,      32'hF8000000,32'd0,      1, 0);
    issue("sll",   32'd1,       32'd99,      32'd0,       0, 2'b10, 3'b001, 7'b0000000, 2'b00, 2'b01, 32'd0,       32'd3,      32'd8,       32'd3,      1, 0);
    issue("and",   32'hF0,      32'h3C,      32'd0,       0, 2'b10, 3'b111, 7'b0000000, 2'b11, 2'b11, 32'd0,       32'd0,      32'h30,      32'h3C,     1, 0);
    issue("or",    32'hF0,      32'h0F,      32'd0,       0, 2'b10, 3'b110, 7'b0000000, 2'b00, 2'b00, 32'd0,       32'd0,      32'hFF,      32'h0F,     1, 0);
    issue("addi",  32'd10,      32'd1,       32'hFFFFFFFD,1, 2'b11, 3'b000, 7'b0100000, 2'b00, 2'b00, 32'd0,       32'd0,      32'd7,       32'd1,      1, 0);

    in_valid = 1'b0;
    @(negedge clk);
    chk("bubble_out_valid", out_valid, 0);
    chk("bubble_hold_res",  alu_result, 32'd7);
    chk("bubble_hold_sd",   store_data, 32'd1);

`ifdef EX_MULDIV_EN
    issue("mul",    32'hFFFFFFFF,32'd3,       32'd0, 0, 2'b10, 3'b000, 7'b0000001, 2'b00, 2'b00, 32'd0,        32'd0,        32'hFFFFFFFD,32'd3,        34, 33);
    issue("mulhu",  32'hFFFFFFFF,32'd3,       32'd0, 0, 2'b10, 3'b011, 7'b0000001, 2'b00, 2'b00, 32'd0,        32'd0,        32'd2,       32'd3,        34, 33);
    issue("mulh",   32'hFFFFFFFE,32'd3,       32'd0, 0, 2'b10, 3'b001, 7'b0000001, 2'b00, 2'b00, 32'd0,        32'd0,        32'hFFFFFFFF,32'd3,        34, 33);
    issue("div_z",  32'd7,       32'd0,       32'd0, 0, 2'b10, 3'b100, 7'b0000001, 2'b00, 2'b00, 32'd0,        32'd0,        32'hFFFFFFFF,32'd0,        34, 33);
    issue("rem_z",  32'd7,       32'd0,       32'd0, 0, 2'b10, 3'b110, 7'b0000001, 2'b00, 2'b00, 32'd0,        32'd0,        32'd7,       32'd0,        34, 33);
    issue("div_ov", 32'd0,       32'd0,       32'd0, 0, 2'b10, 3'b100, 7'b0000001, 2'b10, 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,32'hFFFFFFFF, 34, 33);
    issue("rem_ov", 32'd0,       32'd0,       32'd0, 0, 2'b10, 3'b110, 7'b0000001, 2'b10, 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,       32'hFFFFFFFF, 34, 33);
    issue("divu",   32'd100,     32'd7,       32'd0, 0, 2'b10, 3'b101, 7'b0000001, 2'b00, 2'b00, 32'd0,        32'd0,        32'd14,      32'd7,        34, 33);
    issue("rem_n",  32'hFFFFFFF9,32'd2,       32'd0, 0, 2'b10, 3'b110, 7'b0000001, 2'b00, 2'b00, 32'd0,        32'd0,        32'hFFFFFFFF,32'd2,        34, 33);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    chk("drain_before_reset", sb.size(), 0);

    in_valid = 1'b1; rs1_data = 32'd1000; rs2_data = 32'd3; alu_src = 1'b0;
    alu_op = 2'b10; funct3 = 3'b101; funct7 = 7'b0000001; forwardA = 2'b00; forwardB = 2'b00;
    repeat (10) @(negedge clk);
    chk("divu_busy_stall", stall, 1);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_stall",      stall, 0);
    chk("mid_rst_out_valid",  out_valid, 0);
    chk("mid_rst_alu_result", alu_result, 0);
    chk("mid_rst_zero",       zero, 1);
    rst = 1'b0;
    late_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || stall) late_cnt++;
    end
    chk("no_late_activity", late_cnt, 0);
`else
    issue("mul_off", 32'd3, 32'd4, 32'd0, 0, 2'b10, 3'b000, 7'b0000001, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd4, 1, 0);
    issue("div_off", 32'd9, 32'd3, 32'd0, 0, 2'b10, 3'b100, 7'b0000001, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd3, 1, 0);
    in_valid = 1'b0;
`endif

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
